// File: rtl/router_fsm_nch.sv
// router_fsm_nch: control FSM for a 1-to-NCH packet router.
// It decodes the header address and latches the destination channel.
// It then sequences the header, payload, parity and full-stall phases, and
// decodes the current state into the strobes for the register and
// synchroniser blocks.
//
// Optional feature: define ROUTER_WAIT_TIMEOUT_EN to limit the time spent in
// WAIT_TILL_EMPTY to TIMEOUT_CYCLES. On expiry the packet is dropped and
// timeout_err pulses for one cycle. Without the macro the FSM waits there
// indefinitely and timeout_err is tied low.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   pkt_valid           source packet-valid
//   data_in             header address field
//   fifo_full           full flag of the selected FIFO
//   fifo_empty          per-channel FIFO empty flags
//   soft_reset          per-channel read-timeout soft resets
//   parity_done         parity byte captured
//   low_packet_valid    pkt_valid fell during a full stall
//   detect_add .. drop_state   state-decoded phase strobes
//   dest_sel            registered one-hot destination
//   timeout_err         one-cycle pulse on a wait timeout
module router_fsm_nch #(
  parameter int unsigned NCH            = 3,
  parameter int unsigned ADDR_W         = 2,
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic [NCH-1:0]    fifo_empty,
  input  logic [NCH-1:0]    soft_reset,
  input  logic              parity_done,
  input  logic              low_packet_valid,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              rst_int_reg,
  output logic              write_enb_reg,
  output logic              busy,
  output logic              drop_state,
  output logic [NCH-1:0]    dest_sel,
  output logic              timeout_err
);

  // Flags are widened to the full address space so any address can index them.
  localparam int unsigned EXT_W = 1 << ADDR_W;
  localparam int unsigned CMP_W = ADDR_W + 5;

  typedef enum logic [3:0] {
    DECODE_ADDRESS     = 4'd0,
    LOAD_FIRST_DATA    = 4'd1,
    LOAD_DATA          = 4'd2,
    WAIT_TILL_EMPTY    = 4'd3,
    LOAD_PARITY        = 4'd4,
    CHECK_PARITY_ERROR = 4'd5,
    FIFO_FULL_STATE    = 4'd6,
    LOAD_AFTER_FULL    = 4'd7,
    DROP_PACKET        = 4'd8
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] dest_idx;
  logic [EXT_W-1:0]  empty_ext;
  logic [EXT_W-1:0]  sreset_ext;
  logic              addr_ok;
  logic              abort;

  assign empty_ext  = EXT_W'(fifo_empty);
  assign sreset_ext = EXT_W'(soft_reset);
  assign addr_ok    = CMP_W'(data_in) < CMP_W'(NCH);

  // Only the latched channel's soft reset can abort a packet in flight.
  assign abort = sreset_ext[dest_idx] &&
                 (state != DECODE_ADDRESS) && (state != DROP_PACKET);

`ifdef ROUTER_WAIT_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] wait_cnt;
`else
  assign timeout_err = 1'b0;
`endif

  // State, destination and timeout registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= DECODE_ADDRESS;
      dest_sel <= '0;
      dest_idx <= '0;
`ifdef ROUTER_WAIT_TIMEOUT_EN
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
`ifdef ROUTER_WAIT_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      if (abort) begin
        state    <= DECODE_ADDRESS;
        dest_sel <= '0;
      end else begin
        case (state)
          DECODE_ADDRESS: begin
            if (pkt_valid) begin
              if (addr_ok) begin
                dest_idx <= data_in;
                dest_sel <= NCH'(1) << data_in;
                state    <= empty_ext[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
`ifdef ROUTER_WAIT_TIMEOUT_EN
                wait_cnt <= '0;
`endif
              end else begin
                state <= DROP_PACKET;
              end
            end
          end
          WAIT_TILL_EMPTY: begin
            // Empty wins over a timeout expiring in the same cycle.
            if (empty_ext[dest_idx]) begin
              state <= LOAD_FIRST_DATA;
`ifdef ROUTER_WAIT_TIMEOUT_EN
            end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
              state       <= DROP_PACKET;
              timeout_err <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + CNT_W'(1);
`endif
            end
          end
          LOAD_FIRST_DATA: state <= LOAD_DATA;
          LOAD_DATA: begin
            if (fifo_full)       state <= FIFO_FULL_STATE;
            else if (!pkt_valid) state <= LOAD_PARITY;
          end
          LOAD_PARITY: state <= CHECK_PARITY_ERROR;
          CHECK_PARITY_ERROR: state <= fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
          FIFO_FULL_STATE: begin
            if (!fifo_full) state <= LOAD_AFTER_FULL;
          end
          LOAD_AFTER_FULL: begin
            if (parity_done)           state <= DECODE_ADDRESS;
            else if (low_packet_valid) state <= LOAD_PARITY;
            else                       state <= LOAD_DATA;
          end
          DROP_PACKET: begin
            // The first cycle without pkt_valid carries the discarded parity byte.
            if (!pkt_valid) state <= DECODE_ADDRESS;
          end
          default: state <= DECODE_ADDRESS;
        endcase
      end
    end
  end

  // Moore strobes decoded from the registered state.
  assign detect_add    = (state == DECODE_ADDRESS);
  assign lfd_state     = (state == LOAD_FIRST_DATA);
  assign ld_state      = (state == LOAD_DATA);
  assign laf_state     = (state == LOAD_AFTER_FULL);
  assign full_state    = (state == FIFO_FULL_STATE);
  assign rst_int_reg   = (state == CHECK_PARITY_ERROR);
  assign drop_state    = (state == DROP_PACKET);
  assign write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                         (state == LOAD_AFTER_FULL);
  assign busy          = (state == LOAD_FIRST_DATA) || (state == WAIT_TILL_EMPTY) ||
                         (state == LOAD_PARITY) || (state == CHECK_PARITY_ERROR) ||
                         (state == FIFO_FULL_STATE) || (state == LOAD_AFTER_FULL);

endmodule

// File: tb/tb_router_fsm_nch.sv
// Scoreboard bench for router_fsm_nch (NCH=3, ADDR_W=2, TIMEOUT_CYCLES=8).
// The stimulus pushes the outputs expected after the next rising edge.
// The monitor pops and compares them on the falling edge of that cycle.
module tb_router_fsm_nch;

  // Strobe pattern: {detect_add, lfd, ld, laf, full, rst_int, wen, busy, drop}
  localparam logic [8:0] S_DA  = 9'b100000000;
  localparam logic [8:0] S_LFD = 9'b010000010;
  localparam logic [8:0] S_LD  = 9'b001000100;
  localparam logic [8:0] S_LAF = 9'b000100110;
  localparam logic [8:0] S_FFS = 9'b000010010;
  localparam logic [8:0] S_CPE = 9'b000001010;
  localparam logic [8:0] S_LP  = 9'b000000110;
  localparam logic [8:0] S_WTE = 9'b000000010;
  localparam logic [8:0] S_DRP = 9'b000000001;

  logic       clock = 1'b0;
  logic       reset, pkt_valid, fifo_full, parity_done, low_packet_valid;
  logic [1:0] data_in;
  logic [2:0] fifo_empty, soft_reset;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
  logic       write_enb_reg, busy, drop_state, timeout_err;
  logic [2:0] dest_sel;

  typedef struct {
    int          cyc;
    logic [12:0] exp;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  router_fsm_nch #(.NCH(3), .ADDR_W(2), .TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
    .parity_done(parity_done), .low_packet_valid(low_packet_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .write_enb_reg(write_enb_reg), .busy(busy), .drop_state(drop_state),
    .dest_sel(dest_sel), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  // Monitor: compares every expectation due in the current cycle.
  always @(negedge clock) begin
    logic [12:0] got;
    got = {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
           write_enb_reg, busy, drop_state, dest_sel, timeout_err};
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        errors++;
        $display("FAIL %s: stale expectation for cycle %0d seen at cycle %0d", e.tag, e.cyc, cyc);
      end else if (got !== e.exp) begin
        errors++;
        $display("FAIL %s: got %b required %b (strobes|dest_sel|timeout_err)", e.tag, got, e.exp);
      end
    end
  end

  // Queue the outputs expected after the next edge, then advance one cycle.
  task automatic step(input string tag, input logic [8:0] st, input logic [2:0] ds,
                      input logic to);
    exp_t e;
    e.cyc = cyc + 1;
    e.exp = {st, ds, to};
    e.tag = tag;
    q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
    fifo_empty = 3'b111; soft_reset = 3'b000; parity_done = 1'b0; low_packet_valid = 1'b0;
    @(posedge clock);
    #1;
    step("reset", S_DA, 3'b000, 1'b0);
    reset = 1'b0;
    step("idle", S_DA, 3'b000, 1'b0);

    // Basic packet to channel 1 with three payload bytes.
    pkt_valid = 1'b1; data_in = 2'd1;
    step("t1_hdr", S_LFD, 3'b010, 1'b0);
    data_in = 2'd0;
    step("t1_lfd", S_LD, 3'b010, 1'b0);
    step("t1_ld1", S_LD, 3'b010, 1'b0);
    step("t1_ld2", S_LD, 3'b010, 1'b0);
    pkt_valid = 1'b0;
    step("t1_lp", S_LP, 3'b010, 1'b0);
    step("t1_cpe", S_CPE, 3'b010, 1'b0);
    step("t1_da", S_DA, 3'b010, 1'b0);

    // Wait for channel 1; channel 0's flag is ignored.
    fifo_empty = 3'b101; pkt_valid = 1'b1; data_in = 2'd1;
    step("t2_wte", S_WTE, 3'b010, 1'b0);
    fifo_empty = 3'b100;
    step("t2_tog0a", S_WTE, 3'b010, 1'b0);
    fifo_empty = 3'b101;
    step("t2_tog0b", S_WTE, 3'b010, 1'b0);
    fifo_empty = 3'b111;
    step("t2_lfd", S_LFD, 3'b010, 1'b0);
    pkt_valid = 1'b0;
    step("t2_ld", S_LD, 3'b010, 1'b0);
    step("t2_lp", S_LP, 3'b010, 1'b0);
    step("t2_cpe", S_CPE, 3'b010, 1'b0);
    step("t2_da", S_DA, 3'b010, 1'b0);

    // Full stall; fifo_full beats a simultaneous pkt_valid fall.
    pkt_valid = 1'b1; data_in = 2'd0;
    step("t3_hdr", S_LFD, 3'b001, 1'b0);
    step("t3_ld", S_LD, 3'b001, 1'b0);
    fifo_full = 1'b1; pkt_valid = 1'b0;
    step("t3_ffs1", S_FFS, 3'b001, 1'b0);
    step("t3_ffs2", S_FFS, 3'b001, 1'b0);
    step("t3_ffs3", S_FFS, 3'b001, 1'b0);
    step("t3_ffs4", S_FFS, 3'b001, 1'b0);
    fifo_full = 1'b0; low_packet_valid = 1'b1;
    step("t3_laf", S_LAF, 3'b001, 1'b0);
    step("t3_lp", S_LP, 3'b001, 1'b0);
    low_packet_valid = 1'b0;
    step("t3_cpe", S_CPE, 3'b001, 1'b0);
    step("t3_da", S_DA, 3'b001, 1'b0);

    // Out-of-range address; soft reset of the stale channel has no effect.
    pkt_valid = 1'b1; data_in = 2'd3;
    step("t4_drop", S_DRP, 3'b001, 1'b0);
    soft_reset = 3'b001;
    step("t4_drop_sr", S_DRP, 3'b001, 1'b0);
    soft_reset = 3'b000;
    step("t4_drop3", S_DRP, 3'b001, 1'b0);
    step("t4_drop4", S_DRP, 3'b001, 1'b0);
    step("t4_drop5", S_DRP, 3'b001, 1'b0);
    pkt_valid = 1'b0;
    step("t4_da", S_DA, 3'b001, 1'b0);

    // Soft reset only acts on the latched channel.
    pkt_valid = 1'b1; data_in = 2'd2;
    step("t5_hdr", S_LFD, 3'b100, 1'b0);
    step("t5_ld", S_LD, 3'b100, 1'b0);
    soft_reset = 3'b001;
    step("t5_sr_other", S_LD, 3'b100, 1'b0);
    soft_reset = 3'b100;
    step("t5_sr_dest", S_DA, 3'b000, 1'b0);
    soft_reset = 3'b000; data_in = 2'd1;
    step("t5_hdr2", S_LFD, 3'b010, 1'b0);
    reset = 1'b1; soft_reset = 3'b010;
    step("t5_rst_sr", S_DA, 3'b000, 1'b0);
    reset = 1'b0; soft_reset = 3'b000; pkt_valid = 1'b0;
    step("t5_idle", S_DA, 3'b000, 1'b0);

    // Wait with the flag held low: timeout if enabled, indefinite wait otherwise.
    fifo_empty = 3'b101; pkt_valid = 1'b1; data_in = 2'd1;
    step("t6_wte", S_WTE, 3'b010, 1'b0);
`ifdef ROUTER_WAIT_TIMEOUT_EN
    for (int i = 0; i < 7; i++) step("t6_wte_hold", S_WTE, 3'b010, 1'b0);
    step("t6_timeout", S_DRP, 3'b010, 1'b1);
    step("t6_drop", S_DRP, 3'b010, 1'b0);
    pkt_valid = 1'b0;
    step("t6_da", S_DA, 3'b010, 1'b0);
    pkt_valid = 1'b1;
    step("t6b_wte", S_WTE, 3'b010, 1'b0);
    for (int i = 0; i < 7; i++) step("t6b_wte_hold", S_WTE, 3'b010, 1'b0);
    fifo_empty = 3'b111;
    step("t6b_lfd", S_LFD, 3'b010, 1'b0);
`else
    for (int i = 0; i < 40; i++) step("t6_wte_hold", S_WTE, 3'b010, 1'b0);
    fifo_empty = 3'b111;
    step("t6_lfd", S_LFD, 3'b010, 1'b0);
`endif
    pkt_valid = 1'b0;
    step("t6_ld", S_LD, 3'b010, 1'b0);
    step("t6_lp", S_LP, 3'b010, 1'b0);
    step("t6_cpe", S_CPE, 3'b010, 1'b0);
    step("t6_da", S_DA, 3'b010, 1'b0);

    @(posedge clock);
    @(posedge clock);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
